// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path: default bit timing, frame
// length, the arbiter state encoding and a helper for sizing index fields.
// No ports; imported by uart_tx_arbiter and rr_pick.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;
  localparam int UART_FRAME_BITS      = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    GAP
  } arb_state_e;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Chooses the first set request strictly
// after last_grant, wrapping to the lowest index at or below last_grant.
// Ports:
//   req          in   NUM_REQ  request vector
//   last_grant   in   ID_W     index granted most recently
//   grant_onehot out  NUM_REQ  one-hot winner (zero when no request)
//   grant_idx    out  ID_W     winner index (last_grant when no request)
//   grant_valid  out  1        at least one request present
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  logic            found_hi;
  logic            found_lo;
  logic [ID_W-1:0] idx_hi;
  logic [ID_W-1:0] idx_lo;

  // Split requests into those above last_grant and those at or below it.
  // Scanning downward leaves the lowest index in each half, so no modulo
  // arithmetic is needed and NUM_REQ need not be a power of two.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (ID_W'(i) > last_grant) begin
          found_hi = 1'b1;
          idx_hi   = ID_W'(i);
        end else begin
          found_lo = 1'b1;
          idx_lo   = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    grant_valid  = found_hi | found_lo;
    grant_idx    = found_hi ? idx_hi : (found_lo ? idx_lo : last_grant);
    grant_onehot = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte sources. Grants one byte
// per turn in round-robin order, waits for the transmitter's done pulse (or a
// watchdog timeout), then holds an idle gap before the next grant.
// Ports:
//   clk_100mhz   in   1          system clock
//   btn_reset_n  in   1          synchronous active-low reset
//   req_valid    in   NUM_REQ    requester i has a byte pending
//   req_data     in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//   req_ack      out  NUM_REQ    one-hot capture pulse
//   tx_dv        out  1          start pulse to the transmitter
//   tx_byte      out  8          byte being transmitted
//   tx_active    in   1          transmitter busy
//   tx_done      in   1          transmitter completion pulse
//   busy         out  1          arbiter not idle
//   grant_id     out  ID_W       last granted requester
//   err_timeout  out  1          pulse when tx_done did not arrive in time
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int GAP_CLKS     = CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = (UART_FRAME_BITS + 2) * CLKS_PER_BIT
) (
  input  logic                          clk_100mhz,
  input  logic                          btn_reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [8*NUM_REQ-1:0]          req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          tx_dv,
  output logic [7:0]                    tx_byte,
  input  logic                          tx_active,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [id_width(NUM_REQ)-1:0]  grant_id,
  output logic                          err_timeout
);

  localparam int ID_W    = id_width(NUM_REQ);
  localparam int CNT_MAX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = (GAP_CLKS > 0) ? CNT_W'(GAP_CLKS - 1) : '0;
  localparam logic [ID_W-1:0]  RESET_GRANT  = ID_W'(NUM_REQ - 1);
  localparam arb_state_e       AFTER_BYTE   = (GAP_CLKS == 0) ? IDLE : GAP;

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 err_timeout_q, err_timeout_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req          (req_valid),
    .last_grant   (grant_id_q),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .grant_valid  (pick_valid)
  );

  // Next-state logic. The shared counter times the watchdog in WAIT_DONE and
  // the idle gap in GAP; it is cleared on every state change.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ack_d     = '0;
    tx_dv_d       = 1'b0;
    tx_byte_d     = tx_byte_q;
    grant_id_d    = grant_id_q;
    err_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid && !tx_active) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
              tx_byte_d = req_data[8*i +: 8];
            end
          end
          tx_dv_d    = 1'b1;
          req_ack_d  = pick_onehot;
          grant_id_d = pick_idx;
          cnt_d      = '0;
          state_d    = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // A done pulse landing on the timeout cycle counts as success.
        if (tx_done) begin
          cnt_d   = '0;
          state_d = AFTER_BYTE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_timeout_d = 1'b1;
          cnt_d         = '0;
          state_d       = AFTER_BYTE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any byte in flight.
  always_ff @(posedge clk_100mhz) begin
    if (!btn_reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_ack_q     <= '0;
      tx_dv_q       <= 1'b0;
      tx_byte_q     <= 8'h00;
      grant_id_q    <= RESET_GRANT;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ack_q     <= req_ack_d;
      tx_dv_q       <= tx_dv_d;
      tx_byte_q     <= tx_byte_d;
      grant_id_q    <= grant_id_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign tx_dv       = tx_dv_q;
  assign tx_byte     = tx_byte_q;
  assign grant_id    = grant_id_q;
  assign err_timeout = err_timeout_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (the uart_top TX path, CLKS_PER_BIT timing) between NUM_REQ byte sources, e.g. button-triggered counter, RX echo and status reporter.
- Round-robin grant; one byte per grant.
- Drives the transmitter's data-valid/byte inputs and waits on its done pulse.
- Enforces a programmable inter-byte idle gap and a watchdog timeout per byte.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 10417, clocks per UART bit at 100 MHz / 9600 baud.
- GAP_CLKS, 10417, idle clocks inserted after each byte completes (0 = no gap).
- TIMEOUT_CLKS, 125004, max clocks from tx_dv to tx_done (12 bit times).

Ports:
- clk_100mhz  in  1  system clock.
- btn_reset_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  requester i holds a byte pending.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8*i+7:8*i].
- req_ack  out  NUM_REQ  one-hot, 1-cycle pulse: byte of requester i captured.
- tx_dv  out  1  1-cycle start pulse to the UART transmitter.
- tx_byte  out  8  byte to transmit; stable from the tx_dv cycle until the next capture.
- tx_active  in  1  transmitter busy.
- tx_done  in  1  transmitter 1-cycle completion pulse.
- busy  out  1  arbiter not in IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the last granted requester.
- err_timeout  out  1  1-cycle pulse: tx_done missing within TIMEOUT_CLKS.

Behaviour:
- Reset (btn_reset_n=0 at a clk edge; wins over everything, including mid-byte):
  - state=IDLE; req_ack=0, tx_dv=0, tx_byte=8'h00, busy=0, grant_id=NUM_REQ-1, err_timeout=0, counter=0.
  - A byte in flight at reset is abandoned; its tx_done is ignored.
- States are IDLE, WAIT_DONE, GAP.
- IDLE:
  - Condition: any req_valid=1 and tx_active=0.
  - Winner: first requester with valid set, searching from grant_id+1 upward, modulo NUM_REQ.
  - Next edge: tx_byte<=winner data; tx_dv<=1; req_ack<=onehot(winner); grant_id<=winner; counter<=0; state<=WAIT_DONE.
  - Latency is 1 clock from the valid sample to the tx_dv/ack pulse. tx_dv and req_ack are high in the same cycle.
  - If tx_active=1, no grant is made and the arbiter stays in IDLE.
- Requester contract:
  - Hold valid and data stable until the ack pulse.
  - Valid may stay high for a next byte; it is not resampled before the next IDLE.
- WAIT_DONE:
  - busy=1; counter increments each clock.
  - tx_done=1: go to GAP (or IDLE if GAP_CLKS=0), counter<=0.
  - Timeout: when counter reaches TIMEOUT_CLKS-1 with no tx_done, err_timeout pulses 1 cycle, same next-state rule as tx_done.
  - tx_done and timeout in the same cycle: treat as done; no err_timeout.
- GAP:
  - Count GAP_CLKS clocks, then go to IDLE.
  - Requests arriving during GAP wait; they are not lost because they are level-held.
- Fairness:
  - With all NUM_REQ requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
  - Starvation bound: NUM_REQ-1 bytes.
- Arithmetic:
  - Counter width is clog2(max(TIMEOUT_CLKS,GAP_CLKS)+1).
  - Wrap-around of the rotate search is by index compare; NUM_REQ need not be a power of 2.
- busy is 0 only in IDLE.

Decomposition:
- Package uart_pkg:
  - Constants: DEFAULT_CLKS_PER_BIT=10417, UART_FRAME_BITS=10.
  - Arbiter state enum {IDLE, WAIT_DONE, GAP}.
  - ID width function (clog2).
- Sub-module rr_pick (combinational round-robin picker): inputs req vector and last grant; outputs onehot and index. Reusable by future RX-routing logic.

Test Plan (bench with CLKS_PER_BIT=8, GAP_CLKS=4, TIMEOUT_CLKS=120; real uart transmitter plus a serial line decoder):
- Reset, then req_valid=4'b0001, data0=8'h41 -> one tx_dv pulse with tx_byte=8'h41 and req_ack=4'b0001 one clock after valid; decoder sees 0x41; busy drops GAP_CLKS clocks after tx_done.
- All four valid with data 8'h10,8'h20,8'h30,8'h40, held for 8 bytes -> decoded order 10,20,30,40,10,20,30,40; grant_id sequence 0,1,2,3,0,1,2,3.
- After grant_id=2, requesters 0 and 1 valid -> requester 0 granted next (wrap); then requester 1.
- Transmitter replaced by a stub that never pulses tx_done -> err_timeout pulses exactly 120 clocks after tx_dv; arbiter returns to IDLE after GAP and serves the next request.
- btn_reset_n=0 for 1 cycle mid-WAIT_DONE -> all outputs at reset values the next cycle; grant_id=3; stale tx_done ignored; next request from requester 0 is served normally.
- tx_active held 1 externally with req_valid=4'b1000 -> no tx_dv and no ack; 1 clock after tx_active falls, tx_dv and req_ack=4'b1000 pulse.
